sn74169_driver: RTL and testbench

SN74169_DRIVER -- requirements
Module: sn74169_driver

---
 rtl/sn74169_pkg.sv | 21 ++
 rtl/sn74169_driver.sv | 141 ++++++++++++++
 tb/tb_sn74169_driver.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sn74169_pkg.sv
// Shared types and constants for the sn74169 counter driver.
// Holds the driver FSM state enum, terminal-count values and a step helper.
package sn74169_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_FAULT
    } state_t;

    localparam logic [3:0] TERM_UP = 4'hF;
    localparam logic [3:0] TERM_DN = 4'h0;

    // One count step of the 4-bit counter, wrapping modulo 16.
    function automatic logic [3:0] step(input logic [3:0] v,
                                        input logic       up);
        return up ? v + 4'd1 : v - 4'd1;
    endfunction

endpackage

// File: rtl/sn74169_driver.sv
// Driver and checker for an external sn74169 4-bit up/down counter.
// Ports: clk, rst_n, start, stop, dir_up, preset, limit in; A, LOADB,
// ENPB, ENTB, U_DB to the counter; Q, RCOB back; busy, err, wrap_cnt out.
module sn74169_driver
    import sn74169_pkg::*;
#(
    parameter bit CHECK_EN = 1'b1,
    parameter int WRAP_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              dir_up,
    input  logic [3:0]        preset,
    input  logic [3:0]        limit,
    output logic [3:0]        A,
    output logic              LOADB,
    output logic              ENPB,
    output logic              ENTB,
    output logic              U_DB,
    input  logic [3:0]        Q,
    input  logic              RCOB,
    output logic              busy,
    output logic              err,
    output logic [WRAP_W-1:0] wrap_cnt
);

    state_t            state, state_n;
    logic              synced, synced_n;
    logic              err_q, err_n;
    logic [WRAP_W-1:0] wrap_q, wrap_n;
    logic [3:0]        shadow, shadow_n;
    logic              dir_q, dir_n;
    logic [3:0]        preset_q, preset_n;
    logic [3:0]        limit_q, limit_n;

    logic              en_b;
    logic              rcob_exp;
    logic              mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            synced   <= 1'b0;
            err_q    <= 1'b0;
            wrap_q   <= '0;
            shadow   <= 4'h0;
            dir_q    <= 1'b1;
            preset_q <= 4'h0;
            limit_q  <= 4'h0;
        end else begin
            state    <= state_n;
            synced   <= synced_n;
            err_q    <= err_n;
            wrap_q   <= wrap_n;
            shadow   <= shadow_n;
            dir_q    <= dir_n;
            preset_q <= preset_n;
            limit_q  <= limit_n;
        end
    end

    // Ripple carry the counter should show for the current shadow value.
    always_comb begin
        rcob_exp = 1'b1;
        if (state == ST_RUN) begin
            if (dir_q && shadow == TERM_UP)
                rcob_exp = 1'b0;
            if (!dir_q && shadow == TERM_DN)
                rcob_exp = 1'b0;
        end
    end

    assign mismatch = CHECK_EN && synced && (state != ST_FAULT) &&
                      ((Q != shadow) || (RCOB != rcob_exp));

    always_comb begin
        state_n  = state;
        synced_n = synced;
        err_n    = err_q;
        wrap_n   = wrap_q;
        shadow_n = shadow;
        dir_n    = dir_q;
        preset_n = preset_q;
        limit_n  = limit_q;
        LOADB    = 1'b1;
        en_b     = 1'b1;

        unique case (state)
            ST_IDLE, ST_FAULT: begin
                if (start) begin
                    state_n  = ST_LOAD;
                    dir_n    = dir_up;
                    preset_n = preset;
                    limit_n  = limit;
                    wrap_n   = '0;
                    err_n    = 1'b0;
                    // Counter is not loaded yet; skip the check in LOAD.
                    synced_n = 1'b0;
                end
            end
            ST_LOAD: begin
                LOADB    = 1'b0;
                shadow_n = preset_q;
                synced_n = 1'b1;
                state_n  = ST_RUN;
            end
            ST_RUN: begin
                en_b = 1'b0;
                if (shadow == limit_q) begin
                    LOADB    = 1'b0;
                    shadow_n = preset_q;
                    if (wrap_q != '1)
                        wrap_n = wrap_q + WRAP_W'(1);
                end else begin
                    shadow_n = step(shadow, dir_q);
                end
                if (stop)
                    state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        // Shadow still tracks what the counter did on this edge, but the
        // state and flag go to FAULT regardless of stop or reload.
        if (mismatch) begin
            state_n = ST_FAULT;
            err_n   = 1'b1;
        end
    end

    assign A        = preset_q;
    assign U_DB     = dir_q;
    assign ENPB     = en_b;
    assign ENTB     = en_b;
    assign busy     = (state == ST_LOAD) || (state == ST_RUN);
    assign err      = err_q;
    assign wrap_cnt = wrap_q;

endmodule

// File: tb/tb_sn74169_driver.sv
// Testbench for sn74169_driver with a behavioural sn74169 counter partner.
// Table-driven run patterns plus directed fault, stop, saturation, reset.
module tb_sn74169_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       dir_up = 1'b1;
    logic [3:0] preset = 4'h0;
    logic [3:0] limit = 4'h0;
    logic [3:0] A;
    logic       LOADB, ENPB, ENTB, U_DB;
    logic       busy, err;
    logic [7:0] wrap_cnt;
    logic [3:0] q_cnt = 4'h0;
    logic       rcob_cnt;
    logic       flip = 1'b0;
    logic [3:0] q_dut;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Partner counter: synchronous load wins over count enables.
    always @(posedge clk) begin
        if (!LOADB)
            q_cnt <= A;
        else if (!ENPB && !ENTB)
            q_cnt <= U_DB ? q_cnt + 4'd1 : q_cnt - 4'd1;
    end

    assign rcob_cnt = !(!ENTB && (U_DB ? q_cnt == 4'hF : q_cnt == 4'h0));
    assign q_dut    = q_cnt ^ {3'b000, flip};

    sn74169_driver #(.CHECK_EN(1'b1), .WRAP_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .dir_up(dir_up), .preset(preset), .limit(limit),
        .A(A), .LOADB(LOADB), .ENPB(ENPB), .ENTB(ENTB), .U_DB(U_DB),
        .Q(q_dut), .RCOB(rcob_cnt),
        .busy(busy), .err(err), .wrap_cnt(wrap_cnt)
    );

    typedef struct {
        logic        dir;
        logic [3:0]  pre;
        logic [3:0]  lim;
        logic [31:0] exp_q;
        logic [7:0]  exp_rcob;
        logic [7:0]  exp_wrap;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic d, input logic [3:0] p,
                            input logic [3:0] l);
        dir_up = d;
        preset = p;
        limit  = l;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        logic ok;
        // Q samples are packed oldest-first in the low nibble.
        vecs[0] = '{1'b1, 4'd3,  4'd7,  32'h5437_6543, 8'hFF, 8'd1};
        vecs[1] = '{1'b0, 4'd2,  4'd14, 32'h012E_F012, 8'h7B, 8'd1};
        vecs[2] = '{1'b1, 4'd13, 4'd1,  32'hFED1_0FED, 8'h7B, 8'd1};
        vecs[3] = '{1'b0, 4'd1,  4'd1,  32'h1111_1111, 8'hFF, 8'd7};
        vecs[4] = '{1'b1, 4'd14, 4'd2,  32'h0FE2_10FE, 8'hBD, 8'd1};

        #2 rst_n = 1'b0;
        #1;
        chk("rst_loadb", LOADB, 1);
        chk("rst_enpb", ENPB, 1);
        chk("rst_entb", ENTB, 1);
        chk("rst_a", A, 0);
        chk("rst_udb", U_DB, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_wrap", wrap_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            do_start(vecs[i].dir, vecs[i].pre, vecs[i].lim);
            chk($sformatf("v%0d_loadb", i), LOADB, 0);
            chk($sformatf("v%0d_busy", i), busy, 1);
            chk($sformatf("v%0d_a", i), A, vecs[i].pre);
            chk($sformatf("v%0d_udb", i), U_DB, vecs[i].dir);
            tick();
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("v%0d_q%0d", i, k), q_cnt,
                    (vecs[i].exp_q >> (4 * k)) & 32'hF);
                chk($sformatf("v%0d_rcob%0d", i, k), rcob_cnt,
                    (vecs[i].exp_rcob >> k) & 8'h1);
                if (k < 7)
                    tick();
            end
            chk($sformatf("v%0d_wrap", i), wrap_cnt, vecs[i].exp_wrap);
            chk($sformatf("v%0d_err", i), err, 0);
            do_stop();
            tick();
            chk($sformatf("v%0d_idle", i), busy, 0);
        end

        // preset == limit: Q holds and wrap_cnt saturates.
        do_start(1'b1, 4'd5, 4'd5);
        tick();
        ok = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (q_cnt !== 4'd5)
                ok = 1'b0;
            tick();
        end
        chk("sat_q_hold", ok, 1);
        chk("sat_wrap", wrap_cnt, 255);
        chk("sat_err", err, 0);
        do_stop();
        tick();

        // Single-cycle Q corruption in RUN.
        do_start(1'b1, 4'd3, 4'd7);
        tick();
        tick();
        tick();
        chk("flt_pre_q", q_cnt, 5);
        flip = 1'b1;
        tick();
        flip = 1'b0;
        chk("flt_err", err, 1);
        chk("flt_enpb", ENPB, 1);
        chk("flt_busy", busy, 0);
        do_stop();
        tick();
        chk("flt_q_hold", q_cnt, 6);
        chk("flt_stop_ign", err, 1);
        do_start(1'b1, 4'd9, 4'd12);
        chk("flt_clr_err", err, 0);
        chk("flt_reload_lb", LOADB, 0);
        tick();
        chk("flt_reload_q", q_cnt, 9);
        chk("flt_err_after", err, 0);
        do_stop();
        tick();

        // stop on the reload edge.
        do_start(1'b1, 4'd3, 4'd7);
        tick();
        tick();
        tick();
        tick();
        tick();
        chk("stp_at_lim", q_cnt, 7);
        do_stop();
        chk("stp_q", q_cnt, 3);
        chk("stp_busy", busy, 0);
        chk("stp_wrap", wrap_cnt, 1);
        ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (q_cnt !== 4'd3)
                ok = 1'b0;
        end
        chk("stp_hold", ok, 1);
        chk("stp_err", err, 0);

        // Asynchronous reset in mid-RUN.
        do_start(1'b1, 4'd0, 4'd12);
        begin
            int budget;
            budget = 40;
            while (q_cnt !== 4'd9 && budget > 0) begin
                tick();
                budget--;
            end
            chk("rr_reach9", budget > 0, 1);
        end
        chk("rr_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rr_loadb", LOADB, 1);
        chk("rr_enpb", ENPB, 1);
        chk("rr_a", A, 0);
        chk("rr_udb", U_DB, 1);
        chk("rr_busy", busy, 0);
        tick();
        tick();
        tick();
        chk("rr_q_hold", q_cnt, 9);
        chk("rr_err", err, 0);
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
